// File: rtl/arranque_motores.sv
// Motor start sequencer: single-motor or staggered all-motor start, stop by PARO.
// Optional macro ALTERNANCIA_EN rotates the single-mode motor on every stop (wear levelling).
module arranque_motores #(
  parameter int unsigned N_MOTORES = 4,
  parameter int unsigned RETARDO   = 8
) (
  input  logic                 CLK,
  input  logic                 REINICIO,
  input  logic                 ARRANQUE,
  input  logic                 PARO,
  input  logic                 MODO,
  output logic [N_MOTORES-1:0] MOTORES,
  output logic                 OCUPADO,
  output logic [1:0]           ESTADO
);

  localparam int unsigned CW = $clog2(RETARDO + 1);
  localparam logic [N_MOTORES-1:0] UNO = N_MOTORES'(1);

  typedef enum logic [1:0] {
    REPOSO     = 2'b00,
    ARRANCANDO = 2'b01,
    MARCHA     = 2'b10
  } estado_t;

  estado_t              estado, estado_n;
  logic                 arr_prev;
  logic                 inicio;
  logic [CW-1:0]        cnt, cnt_n;
  logic [N_MOTORES-1:0] mot_n;
  logic [N_MOTORES-1:0] sel;

`ifdef ALTERNANCIA_EN
  localparam int unsigned IW = $clog2(N_MOTORES);
  logic [IW-1:0] idx, idx_n;
  logic          modo_l, modo_l_n;
  assign sel = UNO << idx;
`else
  assign sel = UNO;
`endif

  assign inicio  = ARRANQUE & ~arr_prev;
  assign ESTADO  = estado;
  assign OCUPADO = (estado != REPOSO);

  always_ff @(posedge CLK or negedge REINICIO) begin
    if (!REINICIO) begin
      estado   <= REPOSO;
      arr_prev <= 1'b0;
      cnt      <= '0;
      MOTORES  <= '0;
`ifdef ALTERNANCIA_EN
      idx      <= '0;
      modo_l   <= 1'b0;
`endif
    end else begin
      estado   <= estado_n;
      arr_prev <= ARRANQUE;
      cnt      <= cnt_n;
      MOTORES  <= mot_n;
`ifdef ALTERNANCIA_EN
      idx      <= idx_n;
      modo_l   <= modo_l_n;
`endif
    end
  end

  always_comb begin
    estado_n = estado;
    cnt_n    = cnt;
    mot_n    = MOTORES;
`ifdef ALTERNANCIA_EN
    idx_n    = idx;
    modo_l_n = modo_l;
`endif
    case (estado)
      REPOSO: begin
        if (inicio && !PARO) begin
`ifdef ALTERNANCIA_EN
          modo_l_n = MODO;
`endif
          cnt_n = '0;
          if (!MODO) begin
            mot_n    = sel;
            estado_n = MARCHA;
          end else begin
            mot_n    = UNO;
            estado_n = ARRANCANDO;
          end
        end
      end
      ARRANCANDO: begin
        if (PARO) begin
          mot_n    = '0;
          cnt_n    = '0;
          estado_n = REPOSO;
        end else if (cnt == CW'(RETARDO - 1)) begin
          // Enabled bits are always a contiguous run from bit 0.
          cnt_n = '0;
          mot_n = (MOTORES << 1) | UNO;
          if (mot_n[N_MOTORES-1]) estado_n = MARCHA;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      MARCHA: begin
        if (PARO) begin
          mot_n    = '0;
          cnt_n    = '0;
          estado_n = REPOSO;
`ifdef ALTERNANCIA_EN
          if (!modo_l) idx_n = (idx == IW'(N_MOTORES - 1)) ? '0 : idx + IW'(1);
`endif
        end
      end
      default: begin
        mot_n    = '0;
        cnt_n    = '0;
        estado_n = REPOSO;
      end
    endcase
  end

endmodule
